fsm_ncycles_high: RTL

Parametrised, retriggerable "hold output high for N cycles" controller. It is the successor to the fixed 3-cycle high FSM. A trigger on `x` is qualified for one cycle, then `y` is held high for a run-time-programmable number of cycles, followed by an optional low guard interval. It sits between a raw event/strobe source and logic that needs a clean, minimum-width enable pulse.

---
 rtl/fsm_pkg.sv | 19 +
 rtl/load_down_counter.sv | 49 ++++
 rtl/fsm_ncycles_high.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_pkg
//  Description : Shared types for the stretched-pulse controller family.
//  Revision    : 1.0  - initial release
// ============================================================================
package fsm_pkg;

    // Controller phases: wait for trigger, one-cycle qualify, hold high,
    // forced-low guard interval.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUAL  = 2'd1,
        HOLD  = 2'd2,
        GUARD = 2'd3
    } state_t;

endpackage : fsm_pkg
`default_nettype wire

// File: rtl/load_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : load_down_counter
//  Description : Loadable down counter that saturates at zero. Load has
//                priority over decrement; is_one flags the terminal count.
//  Revision    : 1.0  - initial release
// ============================================================================
module load_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         is_one
);

    localparam logic [W-1:0] c_ONE  = W'(1);
    localparam logic [W-1:0] c_ZERO = '0;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement without wrapping past zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != c_ZERO)) begin
            cnt_d = cnt_q - c_ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= c_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign is_one = (cnt_q == c_ONE);

endmodule : load_down_counter
`default_nettype wire

// File: rtl/fsm_ncycles_high.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_ncycles_high
//  Description : Retriggerable pulse stretcher. A trigger on x is qualified
//                for one cycle, then y is held high for a programmable number
//                of cycles, followed by an optional forced-low guard interval.
//  Revision    : 1.0  - initial release
// ============================================================================
module fsm_ncycles_high
    import fsm_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int GUARD_CYCLES = 1,
    parameter int RETRIGGER    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic [CNT_W-1:0] len,
    output logic             y,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_ZERO      = '0;
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_GUARD_VAL = CNT_W'(GUARD_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q,   len_d;
    logic             done_q,  done_d;

    logic             w_hold_load;
    logic [CNT_W-1:0] w_hold_val;
    logic             w_hold_en;
    logic [CNT_W-1:0] w_hold_cnt;
    logic             w_hold_is_one;
    logic             w_hold_expire;

    logic             w_guard_load;
    logic             w_guard_en;
    logic [CNT_W-1:0] w_guard_cnt;
    logic             w_guard_is_one;
    logic             w_guard_expire;

    // A zero count is treated as expired as well, so the FSM can never stall
    // in HOLD or GUARD even if a counter were somehow left at zero.
    assign w_hold_expire  = w_hold_is_one  || (w_hold_cnt  == c_ZERO);
    assign w_guard_expire = w_guard_is_one || (w_guard_cnt == c_ZERO);

    load_down_counter #(
        .W        (CNT_W)
    ) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_hold_load),
        .load_val (w_hold_val),
        .en       (w_hold_en),
        .cnt      (w_hold_cnt),
        .is_one   (w_hold_is_one)
    );

    generate
        if (GUARD_CYCLES > 0) begin : g_guard
            load_down_counter #(
                .W        (CNT_W)
            ) u_guard_cnt (
                .clk      (clk),
                .rst      (rst),
                .load     (w_guard_load),
                .load_val (c_GUARD_VAL),
                .en       (w_guard_en),
                .cnt      (w_guard_cnt),
                .is_one   (w_guard_is_one)
            );
        end else begin : g_no_guard
            // GUARD is unreachable without a guard interval; tie it off.
            logic w_guard_ctrl_unused;
            assign w_guard_cnt         = c_ZERO;
            assign w_guard_is_one      = 1'b1;
            assign w_guard_ctrl_unused = w_guard_load ^ w_guard_en;
        end
    endgenerate

    // Next-state, counter control and done computation.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        done_d       = 1'b0;
        w_hold_load  = 1'b0;
        w_hold_val   = c_ONE;
        w_hold_en    = 1'b0;
        w_guard_load = 1'b0;
        w_guard_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (x) begin
                    state_d = QUAL;
                    len_d   = len;
                end
            end

            QUAL: begin
                if (x) begin
                    state_d     = HOLD;
                    w_hold_load = 1'b1;
                    w_hold_val  = (len_q == c_ZERO) ? c_ONE : len_q;
                end else begin
                    // Single-cycle strobe: reject as a glitch.
                    state_d = IDLE;
                end
            end

            HOLD: begin
                if ((RETRIGGER != 0) && x) begin
                    // Reload from the live input; beats expiry this cycle.
                    w_hold_load = 1'b1;
                    w_hold_val  = (len == c_ZERO) ? c_ONE : len;
                end else if (w_hold_expire) begin
                    done_d = 1'b1;
                    if (GUARD_CYCLES > 0) begin
                        state_d      = GUARD;
                        w_guard_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    w_hold_en = 1'b1;
                end
            end

            GUARD: begin
                if (w_guard_expire) begin
                    state_d = IDLE;
                end else begin
                    w_guard_en = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched length and done flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= c_ZERO;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    assign y    = (state_q == QUAL) || (state_q == HOLD);
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule : fsm_ncycles_high
`default_nettype wire
